rc_lowpass_filter: RTL



---
 rtl/discrete_pkg.sv | 30 +++
 rtl/rc_lowpass_filter_if.sv | 21 ++
 rtl/rc_lowpass_filter_serial_mult.sv | 50 +++++
 rtl/rc_lowpass_filter.sv | 131 +++++++++++++
 4 files changed

// File: rtl/discrete_pkg.sv
// Shared types, widths and coefficient helpers for the discrete analog-model stages.
package discrete_pkg;

    localparam int SAMPLE_W = 16;
    localparam int ACC_W    = 32;

    typedef enum logic [1:0] {
        IDLE,
        DIFF,
        MUL,
        ACC
    } rc_state_t;

    // Q16 smoothing coefficient for a first-order RC stage sampled at sample_rate:
    // round(65536 / (1 + R*C*fs)), with C given in picofarads, clamped to 1..65535.
    function automatic longint rc_alpha(input longint r, input longint c_pf,
                                        input longint sample_rate);
        longint den;
        longint alpha;
        den   = 64'sd1_000_000_000_000 + r * c_pf * sample_rate;
        alpha = (64'sd65_536_000_000_000_000 + den / 2) / den;
        if (alpha < 1) begin
            alpha = 1;
        end else if (alpha > 65535) begin
            alpha = 65535;
        end
        return alpha;
    endfunction

endpackage

// File: rtl/rc_lowpass_filter_if.sv
// Sample-stream bundle between an audio source and the RC low-pass stage.
interface rc_lowpass_filter_if;
    import discrete_pkg::*;

    logic                audio_clk_en;
    logic [SAMPLE_W-1:0] in;
    logic [SAMPLE_W-1:0] out;
    logic                out_valid;
    logic                overrun;

    modport master (
        output audio_clk_en, in,
        input  out, out_valid, overrun
    );

    modport slave (
        input  audio_clk_en, in,
        output out, out_valid, overrun
    );

endinterface

// File: rtl/rc_lowpass_filter_serial_mult.sv
// 16x16 unsigned shift-add multiplier: one partial product per clk, LSB first.
// done is high during the cycle whose closing edge adds the last partial product.
module serial_mult_16x16
    import discrete_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [SAMPLE_W-1:0] a,
    input  logic [SAMPLE_W-1:0] b,
    output logic                busy,
    output logic                done,
    output logic [ACC_W-1:0]    p
);

    logic [ACC_W-1:0]    a_sh;
    logic [SAMPLE_W-1:0] b_sh;
    logic [3:0]          bit_cnt;

    assign done = busy && (bit_cnt == 4'd15);

    // Load operands on start, then accumulate one shifted partial product per cycle.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) begin
            busy    <= 1'b0;
            bit_cnt <= '0;
            p       <= '0;
            a_sh    <= '0;
            b_sh    <= '0;
        end else if (start) begin
            a_sh    <= ACC_W'(a);
            b_sh    <= b;
            p       <= '0;
            bit_cnt <= '0;
            busy    <= 1'b1;
        end else if (busy) begin
            if (b_sh[0]) begin
                p <= p + a_sh;
            end
            a_sh    <= a_sh << 1;
            b_sh    <= b_sh >> 1;
            bit_cnt <= bit_cnt + 4'd1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/rc_lowpass_filter.sv
// First-order RC low-pass: y += alpha*(x - y) once per audio sample, y held in 16.16.
module rc_lowpass_filter
    import discrete_pkg::*;
#(
    parameter int CLOCK_RATE  = 50000000,
    parameter int SAMPLE_RATE = 48000,
    parameter int R           = 10000,
    parameter int C_PF        = 33000
) (
    input  logic                clk,
    input  logic                reset_n,
    rc_lowpass_filter_if.slave  bus
);

    localparam longint ALPHA_L = rc_alpha(longint'(R), longint'(C_PF), longint'(SAMPLE_RATE));
    localparam logic [SAMPLE_W-1:0] ALPHA = ALPHA_L[SAMPLE_W-1:0];

    // One sample takes 19 clocks; leave margin so a strobe can never outrun the datapath.
    if (CLOCK_RATE / SAMPLE_RATE < 20) begin : g_rate_check
        $error("rc_lowpass_filter: CLOCK_RATE/SAMPLE_RATE must be at least 20");
    end

    rc_state_t           state;
    rc_state_t           state_nx;
    logic [SAMPLE_W-1:0] x_q;
    logic                sign_q;
    logic [ACC_W-1:0]    y_acc;
    logic                out_valid_q;
    logic                overrun_q;

    logic [SAMPLE_W:0]   diff;
    logic [SAMPLE_W-1:0] mag;
    logic                mult_start;
    logic                mult_busy;
    logic                mult_done;
    logic [ACC_W-1:0]    prod;
    logic [ACC_W:0]      acc_sum;
    logic [ACC_W:0]      acc_dif;
    logic [ACC_W-1:0]    acc_next;

    // Signed distance from the current output to the latched input, split into sign and magnitude.
    assign diff = {1'b0, x_q} - {1'b0, y_acc[ACC_W-1:SAMPLE_W]};
    assign mag  = diff[SAMPLE_W] ? SAMPLE_W'(~diff[SAMPLE_W-1:0] + 16'd1) : diff[SAMPLE_W-1:0];

    serial_mult_16x16 u_mult (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (mult_start),
        .a       (mag),
        .b       (ALPHA),
        .busy    (mult_busy),
        .done    (mult_done),
        .p       (prod)
    );

    // Saturating update: the capacitor voltage clips at the rails instead of wrapping.
    always_comb begin
        acc_sum  = {1'b0, y_acc} + {1'b0, prod};
        acc_dif  = {1'b0, y_acc} - {1'b0, prod};
        acc_next = y_acc;
        if (sign_q) begin
            acc_next = acc_dif[ACC_W] ? '0 : acc_dif[ACC_W-1:0];
        end else begin
            acc_next = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
        end
    end

    // Sequencer: IDLE -> DIFF -> MUL (16 cycles) -> ACC -> IDLE.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        state_nx   = state;
        mult_start = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.audio_clk_en) begin
                    state_nx = DIFF;
                end
            end
            DIFF: begin
                mult_start = 1'b1;
                state_nx   = MUL;
            end
            MUL: begin
                if (mult_done) begin
                    state_nx = ACC;
                end else if (!mult_busy) begin
                    state_nx = IDLE;
                end
            end
            ACC: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State register, sample latch, accumulator and status flags.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            x_q         <= '0;
            sign_q      <= 1'b0;
            y_acc       <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state       <= state_nx;
            out_valid_q <= (state == ACC);
            if (bus.audio_clk_en) begin
                if (state == IDLE) begin
                    x_q <= bus.in;
                end else begin
                    overrun_q <= 1'b1;
                end
            end
            if (state == DIFF) begin
                sign_q <= diff[SAMPLE_W];
            end
            if (state == ACC) begin
                y_acc <= acc_next;
            end
        end
    end

    assign bus.out       = y_acc[ACC_W-1:SAMPLE_W];
    assign bus.out_valid = out_valid_q;
    assign bus.overrun   = overrun_q;

endmodule
